// File: rtl/s1_fetch_pc_gen_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, NOP encoding and boot address.
// Also holds the front-end FSM states and a small target-alignment helper.
package s1_fetch_pc_gen_pkg;

   localparam logic [1:0] PC_SEL_SEQ = 2'd0;
   localparam logic [1:0] PC_SEL_ALU = 2'd1;
   localparam logic [1:0] PC_SEL_JAL = 2'd2;
   localparam logic [1:0] PC_SEL_RST = 2'd3;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

   // Instruction addresses are always word aligned; low bits of a computed target are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/s1_fetch_pc_gen.sv
// Stage-1 fetch PC generator: owns the fetch PC, drives the sync-read IMEM/BIOS address,
// and raises the S1/S2 squash strobes on JAL, JALR and taken-branch redirects.
module s1_fetch_pc_gen
   import s1_fetch_pc_gen_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       pc_sel,
   input  logic             redirect_from_s3,
   input  logic [31:0]      alu_target,
   input  logic [31:0]      jal_target,
   input  logic             stall,
   output logic [31:0]      fetch_addr,
   output logic             fetch_valid,
   output logic [31:0]      pc_s1,
   output logic             flush_s1,
   output logic             flush_s2,
   output logic [CNT_W-1:0] redirect_cnt
);

   fetch_state_e      state;
   fetch_state_e      state_next;
   logic [31:0]       pc_reg;
   logic [31:0]       pc_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic              is_redirect;
   logic              count_redirect;

   assign is_redirect    = (pc_sel != PC_SEL_SEQ);
   assign count_redirect = (pc_sel == PC_SEL_ALU) || (pc_sel == PC_SEL_JAL);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_BOOT: state_next = ST_RUN;
         ST_RUN: begin
            if (pc_sel == PC_SEL_RST) begin
               state_next = ST_BOOT;
            end
         end
         default: state_next = ST_BOOT;
      endcase
   end

   // Redirects win over stall so a control transfer is never dropped while fetch is held.
   always_comb begin
      pc_next = pc_reg + 32'd4;
      case (pc_sel)
         PC_SEL_RST: pc_next = RESET_PC;
         PC_SEL_JAL: pc_next = word_align(jal_target);
         PC_SEL_ALU: pc_next = word_align(alu_target);
         default: begin
            if (stall) begin
               pc_next = pc_reg;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_reg  <= RESET_PC;
         cnt_reg <= '0;
      end else if (state == ST_RUN) begin
         pc_reg <= pc_next;
         if (count_redirect) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   // In BOOT the memory output is not yet a fetched word, so both downstream slots are squashed.
   always_comb begin
      fetch_addr  = RESET_PC;
      fetch_valid = 1'b0;
      flush_s1    = 1'b1;
      flush_s2    = 1'b1;
      if (rst) begin
         fetch_valid = 1'b1;
         case (state)
            ST_BOOT: begin
               fetch_addr = pc_reg;
            end
            ST_RUN: begin
               fetch_addr = pc_next;
               flush_s1   = is_redirect;
               flush_s2   = (pc_sel == PC_SEL_RST) ||
                            ((pc_sel == PC_SEL_ALU) && redirect_from_s3);
            end
            default: begin
               fetch_addr = pc_reg;
            end
         endcase
      end
   end

   assign pc_s1        = pc_reg;
   assign redirect_cnt = cnt_reg;

endmodule

// File: tb/tb_s1_fetch_pc_gen.sv
// Self-checking bench for s1_fetch_pc_gen: directed vectors with literal expectations plus
// a per-cycle comparison against an abstract fetch model (redirect counter narrowed to 4 bits).
module tb_s1_fetch_pc_gen;

   localparam logic [31:0] BOOT_PC = 32'h4000_0000;
   localparam int          CNT_W   = 4;

   logic             clk;
   logic             rst;
   logic [1:0]       pc_sel;
   logic             redirect_from_s3;
   logic [31:0]      alu_target;
   logic [31:0]      jal_target;
   logic             stall;
   logic [31:0]      fetch_addr;
   logic             fetch_valid;
   logic [31:0]      pc_s1;
   logic             flush_s1;
   logic             flush_s2;
   logic [CNT_W-1:0] redirect_cnt;

   int check_cnt = 0;
   int fail_cnt  = 0;

   // Model state: architectural PC, whether the next cycle is the boot bubble, redirect count.
   bit          m_known = 0;
   bit          m_boot  = 0;
   logic [31:0] m_pc    = '0;
   int          m_cnt   = 0;

   s1_fetch_pc_gen #(
      .RESET_PC(BOOT_PC),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pc_sel(pc_sel),
      .redirect_from_s3(redirect_from_s3),
      .alu_target(alu_target),
      .jal_target(jal_target),
      .stall(stall),
      .fetch_addr(fetch_addr),
      .fetch_valid(fetch_valid),
      .pc_s1(pc_s1),
      .flush_s1(flush_s1),
      .flush_s2(flush_s2),
      .redirect_cnt(redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_cnt++;
      if (actual !== expected) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [1:0] sel, input logic s3,
                                input logic [31:0] alu, input logic [31:0] jal, input logic stl);
      @(posedge clk);
      #1;
      rst              = r;
      pc_sel           = sel;
      redirect_from_s3 = s3;
      alu_target       = alu;
      jal_target       = jal;
      stall            = stl;
   endtask

   task automatic stepAndSample(input logic r, input logic [1:0] sel, input logic s3,
                                input logic [31:0] alu, input logic [31:0] jal, input logic stl);
      applyStimulus(r, sel, s3, alu, jal, stl);
      @(negedge clk);
   endtask

   function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [1:0] sel,
                                                input logic [31:0] alu, input logic [31:0] jal,
                                                input logic stl);
      if (sel == 2'd3) return BOOT_PC;
      if (sel == 2'd2) return (jal / 4) * 4;
      if (sel == 2'd1) return (alu / 4) * 4;
      if (stl)         return pc;
      return pc + 32'd4;
   endfunction

   always @(posedge clk) begin
      if (rst === 1'b0) begin
         m_known = 1;
         m_boot  = 1;
         m_pc    = BOOT_PC;
         m_cnt   = 0;
      end else if (m_known) begin
         if (m_boot) begin
            m_boot = 0;
         end else begin
            m_pc = model_target(m_pc, pc_sel, alu_target, jal_target, stall);
            if (pc_sel == 2'd1 || pc_sel == 2'd2) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (pc_sel == 2'd3) m_boot = 1;
         end
      end
   end

   // Every cycle the model knows the state, the DUT outputs are compared against it.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checkOutput("model_reset_fetch_addr", fetch_addr, BOOT_PC);
         checkOutput("model_reset_fetch_valid", fetch_valid, 0);
         checkOutput("model_reset_flush_s1", flush_s1, 1);
         checkOutput("model_reset_flush_s2", flush_s2, 1);
         if (m_known) checkOutput("model_reset_cnt", redirect_cnt, m_cnt);
      end else if (m_known) begin
         checkOutput("model_cnt", redirect_cnt, m_cnt);
         checkOutput("model_fetch_valid", fetch_valid, 1);
         if (m_boot) begin
            checkOutput("model_boot_fetch_addr", fetch_addr, m_pc);
            checkOutput("model_boot_flush_s1", flush_s1, 1);
            checkOutput("model_boot_flush_s2", flush_s2, 1);
         end else begin
            checkOutput("model_fetch_addr", fetch_addr,
                        model_target(m_pc, pc_sel, alu_target, jal_target, stall));
            checkOutput("model_pc_s1", pc_s1, m_pc);
            checkOutput("model_flush_s1", flush_s1, pc_sel != 2'd0);
            checkOutput("model_flush_s2", flush_s2,
                        (pc_sel == 2'd3) || (pc_sel == 2'd1 && redirect_from_s3));
         end
      end
   end

   initial begin
      rst = 1'b0; pc_sel = 2'd2; redirect_from_s3 = 1'b0;
      alu_target = '0; jal_target = 32'h1234_5678; stall = 1'b0;

      $display("[TB] reset and boot");
      for (int i = 0; i < 3; i++) stepAndSample(0, 2, 0, 0, 32'h1234_5678, 0);
      checkOutput("reset_fetch_addr", fetch_addr, 32'h4000_0000);
      checkOutput("reset_fetch_valid", fetch_valid, 0);
      checkOutput("reset_flush_s1", flush_s1, 1);
      checkOutput("reset_cnt", redirect_cnt, 0);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("boot_fetch_addr", fetch_addr, 32'h4000_0000);
      checkOutput("boot_flush_s1", flush_s1, 1);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("run0_pc_s1", pc_s1, 32'h4000_0000);
      checkOutput("run0_fetch_addr", fetch_addr, 32'h4000_0004);
      checkOutput("run0_flush_s1", flush_s1, 0);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("run1_fetch_addr", fetch_addr, 32'h4000_0008);

      $display("[TB] stall");
      for (int i = 0; i < 3; i++) begin
         stepAndSample(1, 0, 0, 0, 0, 1);
         checkOutput("stall_fetch_addr", fetch_addr, 32'h4000_0008);
         checkOutput("stall_pc_s1", pc_s1, 32'h4000_0008);
         checkOutput("stall_flush_s1", flush_s1, 0);
      end
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("unstall_fetch_addr", fetch_addr, 32'h4000_000C);

      $display("[TB] taken branch");
      stepAndSample(1, 1, 1, 32'h4000_0103, 0, 0);
      checkOutput("branch_fetch_addr", fetch_addr, 32'h4000_0100);
      checkOutput("branch_flush_s1", flush_s1, 1);
      checkOutput("branch_flush_s2", flush_s2, 1);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("branch_pc_s1", pc_s1, 32'h4000_0100);
      checkOutput("branch_cnt", redirect_cnt, 1);

      $display("[TB] jal under stall");
      stepAndSample(1, 2, 0, 0, 32'h1000_0040, 1);
      checkOutput("jal_fetch_addr", fetch_addr, 32'h1000_0040);
      checkOutput("jal_flush_s1", flush_s1, 1);
      checkOutput("jal_flush_s2", flush_s2, 0);
      stepAndSample(1, 0, 0, 0, 0, 1);
      checkOutput("jal_pc_s1", pc_s1, 32'h1000_0040);
      checkOutput("jal_cnt", redirect_cnt, 2);

      $display("[TB] address wrap and counter wrap");
      stepAndSample(1, 1, 0, 32'hFFFF_FFFE, 0, 0);
      checkOutput("jalr_fetch_addr", fetch_addr, 32'hFFFF_FFFC);
      checkOutput("jalr_flush_s2", flush_s2, 0);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("wrap_fetch_addr", fetch_addr, 32'h0000_0000);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("wrap_pc_s1", pc_s1, 32'h0000_0000);
      checkOutput("pre_wrap_cnt", redirect_cnt, 3);
      for (int i = 0; i < 13; i++) stepAndSample(1, 1, 0, 32'h0000_1000 + 16 * i, 0, 0);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("cnt_wrapped", redirect_cnt, 0);

      $display("[TB] reset during redirect, then restart");
      stepAndSample(0, 1, 1, 32'h2000_0000, 0, 0);
      checkOutput("rst_redirect_fetch_addr", fetch_addr, 32'h4000_0000);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("rst_redirect_boot_addr", fetch_addr, 32'h4000_0000);
      checkOutput("rst_redirect_cnt", redirect_cnt, 0);
      stepAndSample(1, 2, 0, 0, 32'h4000_0200, 0);
      stepAndSample(1, 3, 0, 0, 0, 0);
      checkOutput("restart_fetch_addr", fetch_addr, 32'h4000_0000);
      checkOutput("restart_flush_s2", flush_s2, 1);
      checkOutput("restart_cnt", redirect_cnt, 1);
      stepAndSample(1, 2, 0, 0, 32'h5555_5554, 0);
      checkOutput("restart_boot_addr", fetch_addr, 32'h4000_0000);
      checkOutput("restart_boot_flush_s1", flush_s1, 1);
      stepAndSample(1, 0, 0, 0, 0, 0);
      checkOutput("restart_run_pc_s1", pc_s1, 32'h4000_0000);
      checkOutput("restart_run_cnt", redirect_cnt, 1);

      $display("[TB] mixed vectors");
      for (int i = 0; i < 40; i++) begin
         stepAndSample(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
      $finish;
   end

endmodule
